diag_inv_seq: RTL and testbench
===============================

DIAG_INV_SEQ -- requirements
Module: diag_inv_seq

Interface
REQ-001 Parameter N, default 8, matrix dimension (2..64).
REQ-002 Parameter INV_LAT, default 4, minimum cycles from issuing an element to accepting the reciprocal unit's result.
REQ-003 Parameter TMO_CYC, default 64, maximum cycles to wait for a result before aborting.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a pass; ignored while busy.
REQ-007 mat_rd / mat_addr  out  1 / clog2(N*N)  matrix memory read strobe and element index row*N+col.
REQ-008 mat_rdata  in  16  element in Q3.13, valid exactly one cycle after mat_rd.
REQ-009 inv_en / inv_d  out  1 / 16  enable and operand to the reciprocal unit.
REQ-010 inv_flag / inv_q  in  1 / 16  reciprocal unit ready flag and result in Q4.12.
REQ-011 res_we / res_addr / res_wdata  out  1 / clog2(N) / 16  result-buffer write port for the D^-1 diagonal.
REQ-012 busy / done / err  out  1 each  pass active / one-cycle completion pulse / sticky error.

Function
REQ-013 States: IDLE, RD, RD_WAIT, ISSUE, WAIT_INV, WRITE, FIN; FIN lasts one cycle and returns to IDLE.
REQ-014 IDLE->RD on start; index i cleared to 0; err cleared.
REQ-015 RD: mat_rd=1, mat_addr=i*(N+1) for one cycle; RD_WAIT: capture mat_rdata into the operand register.
REQ-016 ISSUE: drive inv_d with the operand and assert inv_en; clear the latency and timeout counters.
REQ-017 inv_en and inv_d stay asserted and stable for the whole of ISSUE and WAIT_INV.
REQ-018 WAIT_INV: capture inv_q only when inv_flag=1 and the latency counter is at least INV_LAT; inv_flag alone is not sufficient, because the reciprocal unit holds its flag high after its first result.
REQ-019 WRITE: res_we=1 for exactly one cycle, res_addr=i, res_wdata=captured result.
REQ-020 After WRITE: if i<N-1, increment i and go to RD; otherwise go to FIN.
REQ-021 FIN: done=1 for exactly one cycle; busy=1 in every state except IDLE.
REQ-022 Timeout: if the timeout counter reaches TMO_CYC in WAIT_INV, set err, write 16'h7FFF for element i and continue with the next element.
REQ-023 A start arriving in the same cycle as FIN is ignored; a new pass starts only from IDLE.
REQ-024 Nominal per-element latency: 3 cycles plus INV_LAT plus 1 WRITE cycle; full pass: N times that plus 1 cycle.
REQ-025 The counter width is clog2(TMO_CYC+1), and the counter saturates rather than wrapping.

Reset
REQ-026 With rst low: state=IDLE, i=0, counters=0, and all outputs 0 (mat_rd, inv_en, inv_d, res_we, res_addr, res_wdata, busy, done, err).
REQ-027 Reset asserted mid-pass aborts the pass immediately; no further res_we pulse occurs and done is not pulsed.

Configuration
REQ-028 Macro DIAG_ZERO_CHECK_EN.
- Defined: an operand of 16'h0000 is not issued; the block sets err, writes 16'h7FFF to res_wdata, and goes RD_WAIT->WRITE directly.
- Undefined: zero operands are issued like any other element.

Structure
REQ-029 Package diag_pkg holds DW=16, the state enum, SAT_MAX=16'h7FFF and the Q-format constants; it is shared with the reciprocal unit's wrapper.
REQ-030 One sub-module, diag_addr_gen, computes i*(N+1) incrementally by adding N+1 per step, with no multiplier.

Verification
REQ-031 N=4, diagonal {2000,4000,1000,0800}h, ideal reciprocal model with latency 4 -> res writes {1000,0800,2000,4000}h at addresses 0..3, then done once.
REQ-032 Model flag held high from its first result onward -> each capture occurs no earlier than INV_LAT cycles after ISSUE, and no stale value is written.
REQ-033 Model never raises its flag for element 2 -> err=1, res_wdata=7FFF at address 2, elements 3.. still processed, done pulses.
REQ-034 Diagonal element 0000h with DIAG_ZERO_CHECK_EN defined -> inv_en never asserted for that element, 7FFF written, err=1; without the macro -> element issued.
REQ-035 rst pulsed low while WAIT_INV holds i=1 -> all outputs 0 immediately, no later res_we; a following start runs a full clean pass.

Source files
------------

// File: rtl/diag_pkg.sv
// Shared definitions for the diagonal-inverse sequencer and the reciprocal
// unit wrapper: data width, FSM state encoding, saturation value and the
// fixed-point formats on each side of the reciprocal unit.
package diag_pkg;

    localparam int DW = 16;

    // Value written for an element whose reciprocal could not be obtained
    localparam logic [DW-1:0] SAT_MAX = 16'h7FFF;

    // Matrix elements are Q3.13, reciprocal results are Q4.12
    localparam int Q_IN_INT   = 3;
    localparam int Q_IN_FRAC  = 13;
    localparam int Q_OUT_INT  = 4;
    localparam int Q_OUT_FRAC = 12;

    localparam logic [DW-1:0] Q_IN_ONE  = 16'h2000;
    localparam logic [DW-1:0] Q_OUT_ONE = 16'h1000;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        ISSUE,
        WAIT_INV,
        WRITE,
        FIN
    } state_t;

    // True for an operand whose reciprocal is undefined
    function automatic logic is_zero(input logic [DW-1:0] value);
        return value == '0;
    endfunction

endpackage

// File: rtl/diag_addr_gen.sv
// Diagonal address generator: walks row*N+col along the main diagonal by
// adding N+1 per element, so no multiplier is needed.
module diag_addr_gen
    import diag_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [AW-1:0] addr
);

    // Restart at element (0,0) on clear, advance one diagonal step on step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (step) begin
            addr <= addr + AW'(N + 1);
        end
    end

endmodule

// File: rtl/diag_inv_seq.sv
// Diagonal inverse sequencer: reads each diagonal element of an N x N
// matrix, feeds it to an external reciprocal unit, and writes the results
// (the D^-1 diagonal) to a result buffer. Elements whose result never
// arrives are replaced by SAT_MAX and flagged through the sticky err output.
// Optional build macro DIAG_ZERO_CHECK_EN: zero operands are not issued to
// the reciprocal unit; they are written as SAT_MAX and flagged instead.
module diag_inv_seq
    import diag_pkg::*;
#(
    parameter int N       = 8,
    parameter int INV_LAT = 4,
    parameter int TMO_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     mat_rd,
    output logic [$clog2(N*N)-1:0]   mat_addr,
    input  logic [DW-1:0]            mat_rdata,
    output logic                     inv_en,
    output logic [DW-1:0]            inv_d,
    input  logic                     inv_flag,
    input  logic [DW-1:0]            inv_q,
    output logic                     res_we,
    output logic [$clog2(N)-1:0]     res_addr,
    output logic [DW-1:0]            res_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW = $clog2(N * N);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TMO_CYC + 1);
    localparam int LW = (INV_LAT > 0) ? $clog2(INV_LAT + 1) : 1;

    state_t        state;
    logic [IW-1:0] idx;
    logic [LW-1:0] lat_cnt;
    logic [CW-1:0] tmo_cnt;
    logic          last_elem;
    logic          lat_ok;
    logic          tmo_hit;
    logic          addr_clear;
    logic          addr_step;
    logic          zero_skip;

    assign last_elem  = (idx == IW'(N - 1));
    assign lat_ok     = (lat_cnt >= LW'(INV_LAT));
    assign tmo_hit    = (tmo_cnt >= CW'(TMO_CYC));
    assign addr_clear = (state == IDLE) && start;
    assign addr_step  = (state == WRITE) && !last_elem;
    assign res_addr   = idx;

`ifdef DIAG_ZERO_CHECK_EN
    assign zero_skip = is_zero(mat_rdata);
`else
    assign zero_skip = 1'b0;
`endif

    diag_addr_gen #(
        .N  (N),
        .AW (AW)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (addr_clear),
        .step  (addr_step),
        .addr  (mat_addr)
    );

    // Latency and timeout counters: zero in ISSUE, then one count per cycle
    // in WAIT_INV, saturating so a stalled reciprocal unit cannot wrap them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt <= '0;
            tmo_cnt <= '0;
        end else if (state == RD_WAIT) begin
            lat_cnt <= '0;
            tmo_cnt <= '0;
        end else if (state == ISSUE || state == WAIT_INV) begin
            if (lat_cnt != LW'(INV_LAT)) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (tmo_cnt != CW'(TMO_CYC)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Sequencing FSM with all handshake and status outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            mat_rd    <= 1'b0;
            inv_en    <= 1'b0;
            inv_d     <= '0;
            res_we    <= 1'b0;
            res_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        err    <= 1'b0;
                        mat_rd <= 1'b1;
                        busy   <= 1'b1;
                        state  <= RD;
                    end
                end
                RD: begin
                    mat_rd <= 1'b0;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (zero_skip) begin
                        err       <= 1'b1;
                        res_wdata <= SAT_MAX;
                        res_we    <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        inv_d  <= mat_rdata;
                        inv_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_INV;
                end
                WAIT_INV: begin
                    if (inv_flag && lat_ok) begin
                        res_wdata <= inv_q;
                        res_we    <= 1'b1;
                        inv_en    <= 1'b0;
                        inv_d     <= '0;
                        state     <= WRITE;
                    end else if (tmo_hit) begin
                        err       <= 1'b1;
                        res_wdata <= SAT_MAX;
                        res_we    <= 1'b1;
                        inv_en    <= 1'b0;
                        inv_d     <= '0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    res_we <= 1'b0;
                    if (!last_elem) begin
                        idx    <= idx + 1'b1;
                        mat_rd <= 1'b1;
                        state  <= RD;
                    end else begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diag_inv_seq.sv
// Directed self-checking bench for diag_inv_seq with N=4, a behavioural
// matrix memory and a behavioural reciprocal unit (optionally sticky flag,
// optionally never answering for one operand value).
module tb_diag_inv_seq;

    localparam int N        = 4;
    localparam int INV_LAT  = 4;
    localparam int TMO_CYC  = 64;
    localparam int AW       = $clog2(N * N);
    localparam int IW       = $clog2(N);
    localparam int PASS_CYC = N * (4 + INV_LAT) + 1;
    localparam int TMO_PASS = (N - 1) * (4 + INV_LAT) + (4 + TMO_CYC) + 1;
    localparam int ZERO_PASS = (N - 1) * (4 + INV_LAT) + 3 + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mat_rd;
    logic [AW-1:0] mat_addr;
    logic [15:0]   mat_rdata;
    logic          inv_en;
    logic [15:0]   inv_d;
    logic          inv_flag;
    logic [15:0]   inv_q;
    logic          res_we;
    logic [IW-1:0] res_addr;
    logic [15:0]   res_wdata;
    logic          busy;
    logic          done;
    logic          err;

    int cmp_count  = 0;
    int fail_count = 0;

    logic        sticky_mode   = 1'b0;
    logic        block_en      = 1'b0;
    logic [15:0] block_operand = 16'h0000;
    int          mcnt          = 0;

    logic [15:0] mem [0:N*N-1];

    int            cyc       = 0;
    int            wr_cnt    = 0;
    int            issue_cnt = 0;
    int            done_cnt  = 0;
    logic          prev_en   = 1'b0;
    logic [IW-1:0] wr_addr_log  [0:255];
    logic [15:0]   wr_data_log  [0:255];
    int            wr_cyc_log   [0:255];
    logic [15:0]   issue_log    [0:255];
    int            issue_cyc_log[0:255];

    diag_inv_seq #(
        .N       (N),
        .INV_LAT (INV_LAT),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mat_rd    (mat_rd),
        .mat_addr  (mat_addr),
        .mat_rdata (mat_rdata),
        .inv_en    (inv_en),
        .inv_d     (inv_d),
        .inv_flag  (inv_flag),
        .inv_q     (inv_q),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_wdata (res_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal Q3.13 -> Q4.12 reciprocal: 2^25 / x, saturated
    function automatic logic [15:0] model_recip(input logic [15:0] x);
        logic [31:0] q;
        if (x == 16'h0000) return 16'h7FFF;
        q = 32'h0200_0000 / {16'h0000, x};
        if (q > 32'h0000_7FFF) return 16'h7FFF;
        return q[15:0];
    endfunction

    // Matrix memory: data valid one cycle after the read strobe
    always @(posedge clk) begin
        if (mat_rd) mat_rdata <= mem[mat_addr];
    end

    // Reciprocal unit model: result and flag appear on the INV_LAT-th cycle
    // after the operand is first presented
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt     <= 0;
            inv_flag <= 1'b0;
            inv_q    <= 16'h0000;
        end else if (inv_en) begin
            if (mcnt < 1000) mcnt <= mcnt + 1;
            if (mcnt == INV_LAT - 1 && !(block_en && inv_d == block_operand)) begin
                inv_q    <= model_recip(inv_d);
                inv_flag <= 1'b1;
            end
        end else begin
            mcnt <= 0;
            if (!sticky_mode) inv_flag <= 1'b0;
        end
    end

    // Observer: logs writes, issues and done pulses away from the active edge
    always @(negedge clk) begin
        if (res_we) begin
            if (wr_cnt < 256) begin
                wr_addr_log[wr_cnt] = res_addr;
                wr_data_log[wr_cnt] = res_wdata;
                wr_cyc_log[wr_cnt]  = cyc;
            end
            wr_cnt++;
        end
        if (inv_en && !prev_en) begin
            if (issue_cnt < 256) begin
                issue_log[issue_cnt]     = inv_d;
                issue_cyc_log[issue_cnt] = cyc;
            end
            issue_cnt++;
        end
        prev_en = inv_en;
        if (done) done_cnt++;
        cyc++;
    end

    task automatic load_diag(input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
        for (int k = 0; k < N * N; k++) mem[k] = 16'hBEEF;
        mem[0]  = d0;
        mem[5]  = d1;
        mem[10] = d2;
        mem[15] = d3;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts a pass and returns the cycle (1 = RD of element 0) where done is seen
    task automatic run_pass(output int cycles, output bit timed_out);
        pulse_start();
        cycles    = 1;
        timed_out = 1'b0;
        while (!done) begin
            if (cycles >= 2000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        cmp_count++;
        if ({mat_rd, inv_en, inv_d, res_we, res_addr, res_wdata, busy, done, err} !== '0) begin
            fail_count++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {mat_rd, inv_en, inv_d, res_we, res_addr, res_wdata, busy, done, err});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp_count++;
        if ({busy, mat_rd, done} !== 3'b000) begin
            fail_count++;
            $display("[TB] FAIL idle_after_reset: got %b required 000", {busy, mat_rd, done});
        end
        $display("[TB] reset test finished");
    endtask

    task automatic test_nominal();
        logic [15:0] expv [0:N-1];
        int cycles;
        bit to;
        int wbase;
        int dbase;
        expv[0] = 16'h1000; expv[1] = 16'h0800; expv[2] = 16'h2000; expv[3] = 16'h4000;
        load_diag(16'h2000, 16'h4000, 16'h1000, 16'h0800);
        wbase = wr_cnt;
        dbase = done_cnt;
        run_pass(cycles, to);
        cmp_count++;
        if (to || cycles !== PASS_CYC) begin
            fail_count++;
            $display("[TB] FAIL nominal_pass_cycles: got %0d required %0d", cycles, PASS_CYC);
        end
        cmp_count++;
        if (busy !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL busy_in_fin: got %b required 1", busy);
        end
        repeat (3) @(negedge clk);
        cmp_count++;
        if (wr_cnt - wbase !== N) begin
            fail_count++;
            $display("[TB] FAIL nominal_write_count: got %0d required %0d", wr_cnt - wbase, N);
        end
        for (int k = 0; k < N; k++) begin
            cmp_count++;
            if (wr_addr_log[wbase + k] !== IW'(k) || wr_data_log[wbase + k] !== expv[k]) begin
                fail_count++;
                $display("[TB] FAIL nominal_write_%0d: got addr %0d data %h required addr %0d data %h",
                         k, wr_addr_log[wbase + k], wr_data_log[wbase + k], k, expv[k]);
            end
        end
        cmp_count++;
        if (done_cnt - dbase !== 1 || err !== 1'b0 || busy !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL nominal_status: got done_pulses %0d err %b busy %b required 1 0 0",
                     done_cnt - dbase, err, busy);
        end
        $display("[TB] nominal test finished");
    endtask

    task automatic test_sticky_flag();
        logic [15:0] expv [0:N-1];
        int cycles;
        bit to;
        int wbase;
        int ibase;
        expv[0] = 16'h0800; expv[1] = 16'h1000; expv[2] = 16'h4000; expv[3] = 16'h2000;
        load_diag(16'h4000, 16'h2000, 16'h0800, 16'h1000);
        sticky_mode = 1'b1;
        wbase = wr_cnt;
        ibase = issue_cnt;
        run_pass(cycles, to);
        repeat (3) @(negedge clk);
        cmp_count++;
        if (to || wr_cnt - wbase !== N || issue_cnt - ibase !== N) begin
            fail_count++;
            $display("[TB] FAIL sticky_counts: got writes %0d issues %0d required %0d",
                     wr_cnt - wbase, issue_cnt - ibase, N);
        end
        for (int k = 0; k < N; k++) begin
            cmp_count++;
            if (wr_data_log[wbase + k] !== expv[k]) begin
                fail_count++;
                $display("[TB] FAIL sticky_data_%0d: got %h required %h", k, wr_data_log[wbase + k], expv[k]);
            end
            cmp_count++;
            if (wr_cyc_log[wbase + k] - issue_cyc_log[ibase + k] !== INV_LAT + 1) begin
                fail_count++;
                $display("[TB] FAIL sticky_latency_%0d: got %0d required %0d", k,
                         wr_cyc_log[wbase + k] - issue_cyc_log[ibase + k], INV_LAT + 1);
            end
        end
        sticky_mode = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("[TB] sticky flag test finished");
    endtask

    task automatic test_timeout();
        logic [15:0] expv [0:N-1];
        int cycles;
        bit to;
        int wbase;
        int dbase;
        int n;
        expv[0] = 16'h1000; expv[1] = 16'h0800; expv[2] = 16'h7FFF; expv[3] = 16'h4000;
        load_diag(16'h2000, 16'h4000, 16'h1000, 16'h0800);
        block_operand = 16'h1000;
        block_en      = 1'b1;
        wbase = wr_cnt;
        dbase = done_cnt;
        run_pass(cycles, to);
        cmp_count++;
        if (to || cycles !== TMO_PASS) begin
            fail_count++;
            $display("[TB] FAIL timeout_pass_cycles: got %0d required %0d", cycles, TMO_PASS);
        end
        repeat (5) @(negedge clk);
        cmp_count++;
        if (wr_cnt - wbase !== N) begin
            fail_count++;
            $display("[TB] FAIL timeout_write_count: got %0d required %0d", wr_cnt - wbase, N);
        end
        for (int k = 0; k < N; k++) begin
            cmp_count++;
            if (wr_addr_log[wbase + k] !== IW'(k) || wr_data_log[wbase + k] !== expv[k]) begin
                fail_count++;
                $display("[TB] FAIL timeout_write_%0d: got addr %0d data %h required addr %0d data %h",
                         k, wr_addr_log[wbase + k], wr_data_log[wbase + k], k, expv[k]);
            end
        end
        cmp_count++;
        if (err !== 1'b1 || done_cnt - dbase !== 1) begin
            fail_count++;
            $display("[TB] FAIL timeout_status: got err %b done_pulses %0d required 1 1", err, done_cnt - dbase);
        end
        block_en = 1'b0;
        pulse_start();
        cmp_count++;
        if (err !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL err_clear_on_start: got %b required 0", err);
        end
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cmp_count++;
        if (!done) begin
            fail_count++;
            $display("[TB] FAIL clean_pass_done: got no done within %0d cycles required done", n);
        end
        @(negedge clk);
        $display("[TB] timeout test finished");
    endtask

    task automatic test_zero_operand();
        logic [15:0] expv [0:N-1];
        int cycles;
        bit to;
        int wbase;
        int ibase;
        expv[0] = 16'h1000; expv[1] = 16'h7FFF; expv[2] = 16'h2000; expv[3] = 16'h4000;
        load_diag(16'h2000, 16'h0000, 16'h1000, 16'h0800);
        wbase = wr_cnt;
        ibase = issue_cnt;
        run_pass(cycles, to);
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            cmp_count++;
            if (wr_data_log[wbase + k] !== expv[k]) begin
                fail_count++;
                $display("[TB] FAIL zero_data_%0d: got %h required %h", k, wr_data_log[wbase + k], expv[k]);
            end
        end
`ifdef DIAG_ZERO_CHECK_EN
        cmp_count++;
        if (to || cycles !== ZERO_PASS) begin
            fail_count++;
            $display("[TB] FAIL zero_pass_cycles: got %0d required %0d", cycles, ZERO_PASS);
        end
        cmp_count++;
        if (issue_cnt - ibase !== N - 1 || issue_log[ibase + 1] !== 16'h1000) begin
            fail_count++;
            $display("[TB] FAIL zero_not_issued: got issues %0d second %h required %0d 1000",
                     issue_cnt - ibase, issue_log[ibase + 1], N - 1);
        end
        cmp_count++;
        if (err !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL zero_err: got %b required 1", err);
        end
`else
        cmp_count++;
        if (to || cycles !== PASS_CYC) begin
            fail_count++;
            $display("[TB] FAIL zero_pass_cycles: got %0d required %0d", cycles, PASS_CYC);
        end
        cmp_count++;
        if (issue_cnt - ibase !== N || issue_log[ibase + 1] !== 16'h0000) begin
            fail_count++;
            $display("[TB] FAIL zero_issued: got issues %0d second %h required %0d 0000",
                     issue_cnt - ibase, issue_log[ibase + 1], N);
        end
        cmp_count++;
        if (err !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL zero_err: got %b required 0", err);
        end
`endif
        $display("[TB] zero operand test finished");
    endtask

    task automatic test_reset_mid_pass();
        logic [15:0] expv [0:N-1];
        int cycles;
        bit to;
        int wbase;
        int dbase;
        int n;
        expv[0] = 16'h1000; expv[1] = 16'h0800; expv[2] = 16'h2000; expv[3] = 16'h4000;
        load_diag(16'h2000, 16'h4000, 16'h1000, 16'h0800);
        wbase = wr_cnt;
        dbase = done_cnt;
        pulse_start();
        n = 0;
        while (!((wr_cnt - wbase) >= 1 && inv_en) && n < 300) begin
            @(negedge clk);
            n++;
        end
        cmp_count++;
        if (n >= 300) begin
            fail_count++;
            $display("[TB] FAIL reach_element1_issue: got no issue within %0d cycles required issue", n);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        cmp_count++;
        if ({mat_rd, inv_en, inv_d, res_we, res_addr, res_wdata, busy, done, err} !== '0) begin
            fail_count++;
            $display("[TB] FAIL midpass_reset_outputs: got %h required 0",
                     {mat_rd, inv_en, inv_d, res_we, res_addr, res_wdata, busy, done, err});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        cmp_count++;
        if (wr_cnt - wbase !== 1 || done_cnt !== dbase || busy !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL midpass_abort: got writes %0d done_pulses %0d busy %b required 1 0 0",
                     wr_cnt - wbase, done_cnt - dbase, busy);
        end
        wbase = wr_cnt;
        run_pass(cycles, to);
        repeat (3) @(negedge clk);
        cmp_count++;
        if (to || cycles !== PASS_CYC || wr_cnt - wbase !== N) begin
            fail_count++;
            $display("[TB] FAIL after_reset_pass: got cycles %0d writes %0d required %0d %0d",
                     cycles, wr_cnt - wbase, PASS_CYC, N);
        end
        for (int k = 0; k < N; k++) begin
            cmp_count++;
            if (wr_addr_log[wbase + k] !== IW'(k) || wr_data_log[wbase + k] !== expv[k]) begin
                fail_count++;
                $display("[TB] FAIL after_reset_write_%0d: got addr %0d data %h required addr %0d data %h",
                         k, wr_addr_log[wbase + k], wr_data_log[wbase + k], k, expv[k]);
            end
        end
        $display("[TB] mid-pass reset test finished");
    endtask

    task automatic test_back_to_back();
        int n;
        int wbase;
        int dbase;
        load_diag(16'h2000, 16'h4000, 16'h1000, 16'h0800);
        wbase = wr_cnt;
        dbase = done_cnt;
        pulse_start();
        n = 1;
        repeat (9) @(negedge clk);
        n += 9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n++;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cmp_count++;
        if (n !== PASS_CYC) begin
            fail_count++;
            $display("[TB] FAIL start_while_busy: got pass cycles %0d required %0d", n, PASS_CYC);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmp_count++;
        if (busy !== 1'b0 || mat_rd !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL start_in_fin: got busy %b mat_rd %b required 0 0", busy, mat_rd);
        end
        repeat (20) @(negedge clk);
        cmp_count++;
        if (wr_cnt - wbase !== N || done_cnt - dbase !== 1 || busy !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL start_in_fin_idle: got writes %0d done_pulses %0d busy %b required %0d 1 0",
                     wr_cnt - wbase, done_cnt - dbase, busy, N);
        end
        $display("[TB] back-to-back test finished");
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        mat_rdata = 16'h0000;
        for (int k = 0; k < N * N; k++) mem[k] = 16'hBEEF;
        test_reset();
        test_nominal();
        test_sticky_flag();
        test_timeout();
        test_zero_operand();
        test_reset_mid_pass();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
